cdma_despreader: RTL and testbench

Receive-side counterpart to the CDMA spreader in the top-level CDMA design. Regenerates the same LFSR pseudo-noise (PN) sequence from a shared seed and XORs it with the incoming chip stream. Correlates each bit period by majority vote and emits one recovered data bit per period with a valid strobe. Sits between the chip input pin (looped back from the spreader output in bench setups) and the user outputs.

---
 rtl/cdma_pkg.sv | 19 +
 rtl/cdma_lfsr.sv | 45 ++++
 rtl/cdma_despreader.sv | 173 +++++++++++++++++
 tb/tb_cdma_despreader.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/cdma_pkg.sv
// cdma_pkg: constants shared by the CDMA spreader and despreader so both ends
// generate the same PN sequence from the same seed.
package cdma_pkg;

    localparam int                 LFSR_W         = 5;
    localparam logic [LFSR_W-1:0]  TAPS_DEFAULT   = 5'b10100;   // x^5 + x^3 + 1
    localparam int                 CHIPS_DEFAULT  = 32;
    localparam int                 LOCK_N_DEFAULT = 4;
    localparam int                 MARGIN_DEFAULT = 4;

    // An all-zero LFSR would lock up, so a zero seed is replaced by this value.
    localparam logic [LFSR_W-1:0]  SEED_ZERO_SUB  = 5'b00001;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } rx_state_e;

endpackage

// File: rtl/cdma_lfsr.sv
// cdma_lfsr: Fibonacci LFSR PN generator, right-shifting, PN chip = bit 0.
// Shared by spreader and despreader. Reset (active-high, async) loads 1.
module cdma_lfsr
    import cdma_pkg::*;
#(
    parameter int           W    = LFSR_W,
    parameter logic [W-1:0] TAPS = W'(TAPS_DEFAULT)
) (
    input  logic         clk,
    input  logic         rst_n,     // active-high despite the name
    input  logic         load,
    input  logic [W-1:0] seed,
    input  logic         advance,
    output logic         pn
);

    localparam logic [W-1:0] ZSUB = W'(SEED_ZERO_SUB);

    logic [W-1:0] lfsr_q;
    logic [W-1:0] lfsr_d;

    // Next LFSR value: seed load has priority, otherwise shift when advancing.
    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = (seed == {W{1'b0}}) ? ZSUB : seed;
        end else if (advance) begin
            lfsr_d = {^(lfsr_q & TAPS), lfsr_q[W-1:1]};
        end else begin
            lfsr_d = lfsr_q;
        end
    end

    // LFSR state register.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            lfsr_q <= ZSUB;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign pn = lfsr_q[0];

endmodule

// File: rtl/cdma_despreader.sv
// cdma_despreader: XORs received chips with the regenerated PN sequence,
// majority-votes each CHIPS-long bit period and strobes the recovered bit.
// Optional lock tracking is compiled in with `define CDMA_RX_LOCK_EN.
module cdma_despreader
    import cdma_pkg::*;
#(
    parameter int                LFSR_W = cdma_pkg::LFSR_W,
    parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(TAPS_DEFAULT),
    parameter int                CHIPS  = CHIPS_DEFAULT,
    parameter int                LOCK_N = LOCK_N_DEFAULT,
    parameter int                MARGIN = MARGIN_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,     // active-high despite the name
    input  logic              chip_in,
    input  logic [LFSR_W-1:0] seed,
    input  logic              load,
    output logic              bit_out,
    output logic              bit_valid,
    output logic              tie,
    output logic              lock
);

    localparam int                CNT_W     = $clog2(CHIPS);
    localparam int                AGR_W     = $clog2(CHIPS + 1);
    localparam logic [CNT_W-1:0]  LAST_CHIP = CNT_W'(CHIPS - 1);
    localparam logic [AGR_W-1:0]  HALF      = AGR_W'(CHIPS / 2);

    rx_state_e         state_q, state_d;
    logic [CNT_W-1:0]  chip_cnt_q, chip_cnt_d;
    logic [AGR_W-1:0]  agree_q, agree_d;
    logic              bit_out_q, bit_out_d;
    logic              bit_valid_q, bit_valid_d;
    logic              tie_q, tie_d;
    logic              pn_s;
    logic              advance_s;
    logic              last_s;
    logic [AGR_W-1:0]  sum_s;

    assign advance_s = (state_q == ST_RUN) && !load;
    assign last_s    = advance_s && (chip_cnt_q == LAST_CHIP);
    // Agreement so far plus the chip currently on the input.
    assign sum_s     = agree_q + {{(AGR_W-1){1'b0}}, ~(chip_in ^ pn_s)};

    cdma_lfsr #(
        .W    (LFSR_W),
        .TAPS (TAPS)
    ) u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .seed    (seed),
        .advance (advance_s),
        .pn      (pn_s)
    );

    // Correlation and bit decision; load realigns and discards a partial bit.
    always_comb begin
        state_d     = state_q;
        chip_cnt_d  = chip_cnt_q;
        agree_d     = agree_q;
        bit_out_d   = bit_out_q;
        tie_d       = tie_q;
        bit_valid_d = 1'b0;
        if (load) begin
            state_d    = ST_RUN;
            chip_cnt_d = {CNT_W{1'b0}};
            agree_d    = {AGR_W{1'b0}};
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (chip_cnt_q == LAST_CHIP) begin
                        chip_cnt_d  = {CNT_W{1'b0}};
                        agree_d     = {AGR_W{1'b0}};
                        bit_valid_d = 1'b1;
                        if (sum_s < HALF) begin
                            bit_out_d = 1'b1;
                            tie_d     = 1'b0;
                        end else if (sum_s > HALF) begin
                            bit_out_d = 1'b0;
                            tie_d     = 1'b0;
                        end else begin
                            tie_d     = 1'b1;
                        end
                    end else begin
                        chip_cnt_d = chip_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                        agree_d    = sum_s;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q     <= ST_IDLE;
            chip_cnt_q  <= {CNT_W{1'b0}};
            agree_q     <= {AGR_W{1'b0}};
            bit_out_q   <= 1'b0;
            bit_valid_q <= 1'b0;
            tie_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            chip_cnt_q  <= chip_cnt_d;
            agree_q     <= agree_d;
            bit_out_q   <= bit_out_d;
            bit_valid_q <= bit_valid_d;
            tie_q       <= tie_d;
        end
    end

    assign bit_out   = bit_out_q;
    assign bit_valid = bit_valid_q;
    assign tie       = tie_q;

`ifdef CDMA_RX_LOCK_EN
    localparam int               SC_W     = $clog2(LOCK_N + 1);
    localparam logic [SC_W-1:0]  LOCK_MAX = SC_W'(LOCK_N);
    localparam logic [AGR_W-1:0] MARGIN_V = AGR_W'(MARGIN);

    logic [SC_W-1:0]  strong_cnt_q, strong_cnt_d;
    logic             lock_q, lock_d;
    logic [AGR_W-1:0] dev_s;
    logic             strong_s;

    assign dev_s    = (sum_s >= HALF) ? (sum_s - HALF) : (HALF - sum_s);
    assign strong_s = (dev_s >= MARGIN_V);

    // Count consecutive strong decisions; any weak or tie decision resets.
    always_comb begin
        strong_cnt_d = strong_cnt_q;
        lock_d       = lock_q;
        if (load) begin
            strong_cnt_d = {SC_W{1'b0}};
            lock_d       = 1'b0;
        end else if (last_s) begin
            if (strong_s) begin
                if (strong_cnt_q != LOCK_MAX) begin
                    strong_cnt_d = strong_cnt_q + {{(SC_W-1){1'b0}}, 1'b1};
                end else begin
                    strong_cnt_d = strong_cnt_q;
                end
                lock_d = (strong_cnt_d == LOCK_MAX);
            end else begin
                strong_cnt_d = {SC_W{1'b0}};
                lock_d       = 1'b0;
            end
        end else begin
            strong_cnt_d = strong_cnt_q;
        end
    end

    // Lock tracking registers.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            strong_cnt_q <= {SC_W{1'b0}};
            lock_q       <= 1'b0;
        end else begin
            strong_cnt_q <= strong_cnt_d;
            lock_q       <= lock_d;
        end
    end

    assign lock = lock_q;
`else
    assign lock = 1'b0;
`endif

endmodule

// File: tb/tb_cdma_despreader.sv
// tb_cdma_despreader: spreads known/random data with a reference PN model,
// feeds the despreader and compares every decision against a reference
// majority-vote model. Lock expectations follow CDMA_RX_LOCK_EN.
module tb_cdma_despreader;

    localparam logic [4:0] TAPS   = 5'b10100;
    localparam int         CHIPS  = 32;
    localparam int         HALF   = 16;
    localparam int         LOCK_N = 4;
    localparam int         MARGIN = 4;

    logic       clk;
    logic       rst_n;
    logic       chip_in;
    logic [4:0] seed;
    logic       load;
    logic       bit_out;
    logic       bit_valid;
    logic       tie;
    logic       lock;

    int checks;
    int errors;

    // Reference model state
    logic [4:0] m_lfsr;
    logic       m_bit;
    logic       m_tie;
    int         m_strong;

    cdma_despreader #(
        .LFSR_W (5),
        .TAPS   (TAPS),
        .CHIPS  (CHIPS),
        .LOCK_N (LOCK_N),
        .MARGIN (MARGIN)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .chip_in   (chip_in),
        .seed      (seed),
        .load      (load),
        .bit_out   (bit_out),
        .bit_valid (bit_valid),
        .tie       (tie),
        .lock      (lock)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] pn_step(input logic [4:0] r);
        return {^(r & TAPS), r[4:1]};
    endfunction

    function automatic logic exp_lock();
`ifdef CDMA_RX_LOCK_EN
        return (m_strong >= LOCK_N);
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    // Majority-vote decision for a completed bit with agreement count s.
    task automatic decide(input int s);
        int dev;
        if (s < HALF) begin
            m_bit = 1'b1; m_tie = 1'b0;
        end else if (s > HALF) begin
            m_bit = 1'b0; m_tie = 1'b0;
        end else begin
            m_tie = 1'b1;
        end
        dev = (s > HALF) ? s - HALF : HALF - s;
        if (dev >= MARGIN) m_strong++;
        else m_strong = 0;
    endtask

    // Entered at a negedge; drives one full bit, checks the strobe, returns at a negedge.
    task automatic run_bit(input logic data, input int n_inv, input int flip_pct, input string tag);
        int   s;
        bit   early;
        logic inv;
        logic pn;
        s = 0;
        early = 1'b0;
        for (int i = 0; i < CHIPS; i++) begin
            if (i > 0) begin
                @(negedge clk);
                if (bit_valid) early = 1'b1;
            end
            inv = (i < n_inv) || ($urandom_range(0, 99) < flip_pct);
            pn = m_lfsr[0];
            chip_in = data ^ pn ^ inv;
            if (chip_in == pn) s++;
            m_lfsr = pn_step(m_lfsr);
        end
        @(negedge clk);
        decide(s);
        chk({tag, " early_strobe"}, early, 1'b0);
        chk({tag, " bit_valid"}, bit_valid, 1'b1);
        chk({tag, " bit_out"}, bit_out, m_bit);
        chk({tag, " tie"}, tie, m_tie);
        chk({tag, " lock"}, lock, exp_lock());
    endtask

    // Drives n chips of a bit without completing it; returns at a negedge.
    task automatic partial_bit(input logic data, input int n);
        logic pn;
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            pn = m_lfsr[0];
            chip_in = data ^ pn;
            m_lfsr = pn_step(m_lfsr);
        end
        @(negedge clk);
    endtask

    // One-cycle seed load; returns at a negedge with load released.
    task automatic do_load(input logic [4:0] s, input string tag);
        load = 1'b1;
        seed = s;
        chip_in = 1'($urandom);
        @(negedge clk);
        load = 1'b0;
        m_lfsr = (s == 5'd0) ? 5'd1 : s;
        m_strong = 0;
        chk({tag, " no_strobe"}, bit_valid, 1'b0);
        chk({tag, " lock_cleared"}, lock, 1'b0);
    endtask

    initial begin
        bit seen;
        checks = 0;
        errors = 0;
        m_lfsr = 5'd1;
        m_bit = 1'b0;
        m_tie = 1'b0;
        m_strong = 0;
        rst_n = 1'b1;
        chip_in = 1'b0;
        seed = 5'd0;
        load = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset bit_out", bit_out, 1'b0);
        chk("reset bit_valid", bit_valid, 1'b0);
        chk("reset tie", tie, 1'b0);
        chk("reset lock", lock, 1'b0);
        rst_n = 1'b0;

        // IDLE: chips ignored, no strobes
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            chip_in = 1'($urandom);
            @(negedge clk);
            if (bit_valid) seen = 1'b1;
        end
        chk("idle no_strobe", seen, 1'b0);

        // Loopback, seed 01101, data toggling from 0
        do_load(5'b01101, "load_a");
        for (int b = 0; b < 8; b++) run_bit(1'(b & 1), 0, 0, "loopback");

        // Clean data 1 (S = 0), then 15 inverted chips in a data-0 bit (S = 17)
        run_bit(1'b1, 0, 0, "clean_one");
        run_bit(1'b0, 15, 0, "inv15");
        // Prime bit_out = 1, then 16 inverted chips -> tie, bit_out holds 1
        run_bit(1'b1, 0, 0, "clean_one_b");
        run_bit(1'b0, 16, 0, "inv16_tie");
        run_bit(1'b0, 0, 0, "after_tie");

        // Randomized data and noise
        for (int b = 0; b < 12; b++) begin
            run_bit(1'($urandom), 0, int'($urandom_range(0, 60)), "random");
        end

        // Zero seed behaves as seed 1
        do_load(5'd0, "load_zero");
        for (int b = 0; b < 3; b++) run_bit(1'($urandom), 0, 10, "seed_zero");

        // Realign at chip 20: that bit is discarded
        partial_bit(1'b1, 20);
        do_load(5'b10011, "load_mid");
        run_bit(1'b0, 0, 0, "after_mid_load");

        // Load coinciding with the final chip: load wins
        partial_bit(1'b1, 31);
        do_load(5'b00111, "load_last");
        for (int b = 0; b < 5; b++) run_bit(1'b1, 0, 0, "after_last_load");

        // Reset mid-bit: outputs clear asynchronously, IDLE until a new load
        partial_bit(1'b0, 10);
        #2 rst_n = 1'b1;
        #1;
        m_bit = 1'b0; m_tie = 1'b0; m_strong = 0;
        chk("async_rst bit_out", bit_out, 1'b0);
        chk("async_rst bit_valid", bit_valid, 1'b0);
        chk("async_rst tie", tie, 1'b0);
        chk("async_rst lock", lock, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            chip_in = 1'($urandom);
            @(negedge clk);
            if (bit_valid) seen = 1'b1;
        end
        chk("post_rst no_strobe", seen, 1'b0);
        chk("post_rst bit_out", bit_out, 1'b0);
        do_load(5'b01101, "load_post_rst");
        for (int b = 0; b < 5; b++) run_bit(1'($urandom), 0, 5, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
